// File: rtl/qlf_bram_fifo_pkg.sv
// Shared definitions for the BRAM simple-dual-port FIFO controller:
// depth and level-width rules derived from the address width, and the
// default almost-full / almost-empty thresholds.
package qlf_bram_fifo_pkg;

    // RAM depth for a given address width.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Level must count DEPTH words in RAM plus the head word (DEPTH+1).
    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction

    // Almost-full sits this many words below DEPTH by default.
    localparam int AF_MARGIN_DEFAULT = 4;
    // Almost-empty threshold by default.
    localparam int AE_THRESH_DEFAULT = 4;

endpackage

// File: rtl/bram_sdp_fifo_ptr.sv
// One wrapping RAM address pointer with synchronous clear and increment.
// Instantiated twice by bram_sdp_fifo_ctrl, for the write and read sides.
module bram_sdp_fifo_ptr
    import qlf_bram_fifo_pkg::*;
#(
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [AWIDTH-1:0] ptr
);

    // Pointer wraps naturally modulo DEPTH; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + AWIDTH'(1);
        end
    end

endmodule

// File: rtl/bram_sdp_fifo_ctrl.sv
// Sequencer that turns one simple-dual-port BRAM with a registered read
// port (1-cycle latency) into a first-word-fall-through FIFO. The RAM
// macro lives beside this block; we only drive its enables and addresses.
// The head word is held in the RAM output register (ram_rq), so total
// capacity is DEPTH+1 words.
//
// Optional feature: define BRAM_SDP_FIFO_ALMOST_EN to add the registered
// almost_full / almost_empty outputs and their AF_THRESH / AE_THRESH
// parameters.
//
// Handshake: a word is written when push && !full in a cycle; a word is
// consumed when pop && !empty in a cycle (rdata is the word consumed).
// Push while full is dropped and sets ovf; pop while empty is ignored and
// sets udf. Both flags are sticky until flush or reset.
module bram_sdp_fifo_ctrl
    import qlf_bram_fifo_pkg::*;
#(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
`ifdef BRAM_SDP_FIFO_ALMOST_EN
    ,
    parameter int AF_THRESH = fifo_depth(AWIDTH) - AF_MARGIN_DEFAULT,
    parameter int AE_THRESH = AE_THRESH_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    output logic              full,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              empty,
    output logic [AWIDTH:0]   level,
    output logic              ovf,
    output logic              udf,
    output logic              ram_wce,
    output logic [AWIDTH-1:0] ram_wa,
    output logic [DWIDTH-1:0] ram_wd,
    output logic              ram_rce,
    output logic [AWIDTH-1:0] ram_ra,
    input  logic [DWIDTH-1:0] ram_rq
`ifdef BRAM_SDP_FIFO_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int             LW      = level_width(AWIDTH);
    localparam logic [LW-1:0]  DEPTH_L = LW'(fifo_depth(AWIDTH));

    logic [LW-1:0] ram_cnt;
    logic [LW-1:0] ram_cnt_nxt;
    logic          head_valid;
    logic          head_valid_nxt;
    logic          pop_ok;

    // Enables and next-state; flush suppresses both RAM enables.
    always_comb begin
        pop_ok         = pop && head_valid;
        ram_wce        = push && !full && !flush;
        ram_rce        = (ram_cnt != '0) && (!head_valid || pop_ok) && !flush;
        head_valid_nxt = ram_rce || (head_valid && !pop_ok);
        ram_cnt_nxt    = ram_cnt;
        case ({ram_wce, ram_rce})
            2'b10:   ram_cnt_nxt = ram_cnt + LW'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - LW'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase
        if (flush) begin
            head_valid_nxt = 1'b0;
            ram_cnt_nxt    = '0;
        end
    end

    bram_sdp_fifo_ptr #(.AWIDTH(AWIDTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (ram_wce),
        .ptr   (ram_wa)
    );

    bram_sdp_fifo_ptr #(.AWIDTH(AWIDTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (ram_rce),
        .ptr   (ram_ra)
    );

    // RAM word count and head-valid state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_cnt    <= '0;
            head_valid <= 1'b0;
        end else begin
            ram_cnt    <= ram_cnt_nxt;
            head_valid <= head_valid_nxt;
        end
    end

    // Sticky overflow / underflow flags, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf || (push && full);
            udf <= udf || (pop && !head_valid);
        end
    end

    assign full   = (ram_cnt == DEPTH_L);
    assign empty  = !head_valid;
    assign level  = ram_cnt + {{(LW-1){1'b0}}, head_valid};
    assign rdata  = ram_rq;
    assign ram_wd = wdata;

`ifdef BRAM_SDP_FIFO_ALMOST_EN
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);

    logic [LW-1:0] level_nxt;
    assign level_nxt = ram_cnt_nxt + {{(LW-1){1'b0}}, head_valid_nxt};

    // Registered from next-state level so the flags line up with level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (level_nxt >= AF_L);
            almost_empty <= (level_nxt <= AE_L);
        end
    end
`endif

endmodule
